// File: rtl/complex_addsub_pipe.sv
// Two-stage pipelined complex adder/subtractor with valid/ready flow control on
// both sides, per-component overflow flags and optional saturation.
module complex_addsub_pipe #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] real_a,
  input  logic signed [WIDTH-1:0] im_a,
  input  logic signed [WIDTH-1:0] real_b,
  input  logic signed [WIDTH-1:0] im_b,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out,
  output logic [1:0]              ovf
);

  typedef enum logic [1:0] {
    OP_A_MINUS_B     = 2'b00,
    OP_A_PLUS_B      = 2'b01,
    OP_B_MINUS_A     = 2'b10,
    OP_A_PLUS_CONJ_B = 2'b11
  } op_e;

  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // The raw result carries one guard bit; a mismatch with the sign bit below it
  // means the value does not fit in WIDTH bits.
  function automatic logic ovf_of(input logic signed [WIDTH:0] raw);
    return raw[WIDTH] ^ raw[WIDTH-1];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_of(input logic signed [WIDTH:0] raw);
    if (SATURATE && ovf_of(raw)) begin
      return raw[WIDTH] ? MIN_VAL : MAX_VAL;
    end
    return raw[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] re_a_p0, im_a_p0, re_b_p0, im_b_p0;
  logic signed [WIDTH:0] raw_re_p0, raw_im_p0;
  logic signed [WIDTH:0] raw_re_p1, raw_im_p1;
  logic                  vld_p1;
  logic signed [WIDTH-1:0] res_re_p2, res_im_p2;
  logic [1:0]            ovf_p2;
  logic                  vld_p2;
  logic                  s2_load;

  // ---- stage 0: sign extension and operation select ----
  assign re_a_p0 = {real_a[WIDTH-1], real_a};
  assign im_a_p0 = {im_a[WIDTH-1], im_a};
  assign re_b_p0 = {real_b[WIDTH-1], real_b};
  assign im_b_p0 = {im_b[WIDTH-1], im_b};

  always_comb begin
    raw_re_p0 = re_a_p0 - re_b_p0;
    raw_im_p0 = im_a_p0 - im_b_p0;
    case (mode)
      OP_A_MINUS_B: begin
        raw_re_p0 = re_a_p0 - re_b_p0;
        raw_im_p0 = im_a_p0 - im_b_p0;
      end
      OP_A_PLUS_B: begin
        raw_re_p0 = re_a_p0 + re_b_p0;
        raw_im_p0 = im_a_p0 + im_b_p0;
      end
      OP_B_MINUS_A: begin
        raw_re_p0 = re_b_p0 - re_a_p0;
        raw_im_p0 = im_b_p0 - im_a_p0;
      end
      OP_A_PLUS_CONJ_B: begin
        raw_re_p0 = re_a_p0 + re_b_p0;
        raw_im_p0 = im_a_p0 - im_b_p0;
      end
      default: ;
    endcase
  end

  // Stage 2 may advance when empty or draining; stage 1 when stage 2 frees up.
  assign s2_load  = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_load;

  // ---- stage 1: raw WIDTH+1-bit results ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1    <= 1'b0;
      raw_re_p1 <= '0;
      raw_im_p1 <= '0;
    end else if (in_ready) begin
      vld_p1    <= in_valid;
      raw_re_p1 <= raw_re_p0;
      raw_im_p1 <= raw_im_p0;
    end
  end

  // ---- stage 2: overflow detection, wrap or saturate ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p2    <= 1'b0;
      res_re_p2 <= '0;
      res_im_p2 <= '0;
      ovf_p2    <= 2'b00;
    end else if (s2_load) begin
      vld_p2    <= vld_p1;
      res_re_p2 <= sat_of(raw_re_p1);
      res_im_p2 <= sat_of(raw_im_p1);
      ovf_p2    <= {ovf_of(raw_re_p1), ovf_of(raw_im_p1)};
    end
  end

  assign out_valid = vld_p2;
  assign out       = {res_re_p2, res_im_p2};
  assign ovf       = ovf_p2;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Scoreboard bench: wrapping and saturating instances share stimulus; results
// are checked against an integer reference model of the four operations.
`timescale 1ns/1ps
module tb_complex_addsub_pipe;

  localparam int W    = 16;
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));

  typedef struct {
    logic [2*W-1:0] out;
    logic [1:0]     ovf;
    int             acc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic in_valid, out_ready;
  logic signed [W-1:0] real_a, im_a, real_b, im_b;
  logic [1:0] mode;
  logic in_ready_w, in_ready_s, out_valid_w, out_valid_s;
  logic [2*W-1:0] out_w, out_s;
  logic [1:0] ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;
  exp_t q_w[$];
  exp_t q_s[$];
  bit stall[2];
  logic [2*W-1:0] prev_o[2];
  logic [1:0] prev_f[2];

  complex_addsub_pipe #(.WIDTH(W), .SATURATE(1'b0)) dut_w (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .real_a(real_a), .im_a(im_a), .real_b(real_b), .im_b(im_b), .mode(mode),
    .out_valid(out_valid_w), .out_ready(out_ready), .out(out_w), .ovf(ovf_w));

  complex_addsub_pipe #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .real_a(real_a), .im_a(im_a), .real_b(real_b), .im_b(im_b), .mode(mode),
    .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s), .ovf(ovf_s));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] fit(input int v, input bit sat);
    if (sat && v > MAXV) return W'(MAXV);
    if (sat && v < MINV) return W'(MINV);
    return W'(v);
  endfunction

  // Reference: exact integer result, then range test and wrap/clamp.
  function automatic exp_t model(input int ra, ia, rb, ib, input logic [1:0] m, input bit sat);
    exp_t e;
    int r, i;
    case (m)
      2'd0: begin r = ra - rb; i = ia - ib; end
      2'd1: begin r = ra + rb; i = ia + ib; end
      2'd2: begin r = rb - ra; i = ib - ia; end
      default: begin r = ra + rb; i = ia - ib; end
    endcase
    e.ovf = {(r > MAXV || r < MINV), (i > MAXV || i < MINV)};
    e.out = {fit(r, sat), fit(i, sat)};
    e.acc = 0;
    return e;
  endfunction

  task automatic mon(input int d, input logic ov, input logic [2*W-1:0] o, input logic [1:0] f);
    exp_t e;
    if (stall[d]) begin
      chk($sformatf("hold_valid_d%0d", d), ov, 1'b1);
      chk($sformatf("hold_out_d%0d", d), o, prev_o[d]);
      chk($sformatf("hold_ovf_d%0d", d), f, prev_f[d]);
    end
    if (ov && out_ready) begin
      if ((d == 0 && q_w.size() == 0) || (d == 1 && q_s.size() == 0)) begin
        chk($sformatf("spurious_d%0d", d), 1'b1, 1'b0);
      end else begin
        e = (d == 0) ? q_w.pop_front() : q_s.pop_front();
        chk($sformatf("out_d%0d", d), o, e.out);
        chk($sformatf("ovf_d%0d", d), f, e.ovf);
        if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'd2);
      end
    end
    stall[d]  = ov && !out_ready;
    prev_o[d] = o;
    prev_f[d] = f;
  endtask

  // Monitor first, then record acceptances, both on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      mon(0, out_valid_w, out_w, ovf_w);
      mon(1, out_valid_s, out_s, ovf_s);
      if (in_valid && in_ready_w) begin
        e = model(int'(real_a), int'(im_a), int'(real_b), int'(im_b), mode, 1'b0);
        e.acc = cyc;
        q_w.push_back(e);
        e = model(int'(real_a), int'(im_a), int'(real_b), int'(im_b), mode, 1'b1);
        e.acc = cyc;
        q_s.push_back(e);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int ra, ia, rb, ib, input logic [1:0] m);
    bit ok;
    real_a = W'(ra); im_a = W'(ia); real_b = W'(rb); im_b = W'(ib); mode = m;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (in_ready_w) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (q_w.size() == 0 && q_s.size() == 0) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
    chk("drain", ok, 1'b1);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 7))
      0: return MAXV;
      1: return MINV;
      2: return 0;
      3: return -1;
      default: return int'($signed(W'($urandom)));
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    real_a = '0; im_a = '0; real_b = '0; im_b = '0; mode = 2'b00;
    #1;
    chk("rst_out_valid", {out_valid_w, out_valid_s}, 2'b00);
    chk("rst_out", {out_w, out_s}, 64'd0);
    chk("rst_ovf", {ovf_w, ovf_s}, 4'd0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("rst_in_ready", {in_ready_w, in_ready_s}, 2'b11);
    next_cycle();

    // Directed modes, overflow corners, fixed latency.
    lat_chk = 1'b1;
    for (int m = 0; m < 4; m++) send(5, -3, 2, 7, 2'(m));
    send(30000, -30000, 30000, -30000, 2'd1);
    send(MAXV, 0, 0, 0, 2'd1);
    send(MINV, MINV, 0, 0, 2'd2);
    send(MINV, MAXV, 1, MINV, 2'd3);
    send(MINV, MAXV, 1, -1, 2'd0);
    drain();

    // Full throughput: 100 back-to-back transfers.
    for (int i = 0; i < 100; i++) begin
      real_a = W'(rnd_val()); im_a = W'(rnd_val());
      real_b = W'(rnd_val()); im_b = W'(rnd_val());
      mode = 2'($urandom_range(0, 3));
      in_valid = 1'b1;
      @(negedge clock);
      chk("tput_in_ready", in_ready_w, 1'b1);
      if (i >= 2) chk("tput_out_valid", out_valid_w, 1'b1);
      next_cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("tput_tail_valid", out_valid_w, 1'b1);
      next_cycle();
    end
    drain();
    lat_chk = 1'b0;

    // Backpressure: out_ready low for cycles 3..7 of a 6-transaction stream.
    fork
      for (int i = 0; i < 6; i++) send(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
      for (int c = 0; c < 12; c++) begin
        out_ready = !(c >= 3 && c <= 7);
        if (c == 5) begin
          @(negedge clock);
          chk("bp_in_ready_low", in_ready_w, 1'b0);
          chk("bp_out_valid", out_valid_w, 1'b1);
        end
        next_cycle();
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with two transactions parked.
    out_ready = 1'b0;
    send(11, 22, 33, 44, 2'd1);
    send(-5, 6, 7, -8, 2'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", {out_valid_w, out_valid_s}, 2'b00);
    chk("async_rst_out", {out_w, out_s}, 64'd0);
    chk("async_rst_ovf", {ovf_w, ovf_s}, 4'd0);
    q_w.delete();
    q_s.delete();
    @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("post_rst_in_ready", in_ready_w, 1'b1);
    out_ready = 1'b1;
    next_cycle();
    send(1000, -2000, 3000, -4000, 2'd3);
    drain();

    // Randomised handshakes on both sides.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) next_cycle();
          send(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
        end
        done = 1'b1;
      end
      while (!done) begin
        out_ready = ($urandom_range(0, 3) != 0);
        next_cycle();
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
